// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//   Write-side controller for a clock-crossing FIFO. NUM_REQ requesters share
//   the single RAM write port through a round-robin arbiter. A requester that
//   starts a multi-word burst (req_last=0) keeps the port until it delivers its
//   last word. The block owns the binary/Gray write pointer and computes full
//   and fill level against the read pointer, which is already synchronised
//   into aclk.
//
// Ports
//   aclk, areset      write-domain clock, synchronous active-high reset
//   req_valid/last    per-requester word valid / last word of burst
//   req_data          requester i at bits [i*DWIDTH +: DWIDTH]
//   req_ready         per-requester accept (one-hot or zero, combinational)
//   rd_ptr_gray_sync  Gray read pointer, synchronised to aclk
//   wr_en/addr/data   RAM write interface, one cycle after the accept
//   wr_ptr_gray       registered Gray write pointer for the read-side sync
//   full, fill_level  registered full flag and occupancy (0..2**AWIDTH)
//   grant_id          index of the current/last granted requester
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 4,
  localparam int IW     = $clog2(NUM_REQ),
  localparam int PW     = AWIDTH + 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [PW-1:0]             rd_ptr_gray_sync,
  output logic                      wr_en,
  output logic [AWIDTH-1:0]         wr_addr,
  output logic [DWIDTH-1:0]         wr_data,
  output logic [PW-1:0]             wr_ptr_gray,
  output logic                      full,
  output logic [PW-1:0]             fill_level,
  output logic [IW-1:0]             grant_id
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_grant_id;
  logic [PW-1:0]     r_wr_bin;
  logic [PW-1:0]     r_wr_ptr_gray;
  logic [PW-1:0]     r_fill;
  logic              r_full;
  logic              r_wr_en;
  logic [AWIDTH-1:0] r_wr_addr;
  logic [DWIDTH-1:0] r_wr_data;

  logic [IW:0]       w_pick;
  logic [IW-1:0]     w_sel_id;
  logic              w_sel_vld;
  logic              w_acc;
  logic              w_acc_last;
  logic [DWIDTH-1:0] w_acc_data;
  logic [PW-1:0]     w_next_bin;
  logic [PW-1:0]     w_next_gray;
  logic [PW-1:0]     w_rd_bin;
  logic [PW-1:0]     w_full_cmp;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + IW'(1);
  endfunction

  // Returns {found, index} of the first valid requester at or after start,
  // wrapping at NUM_REQ (which need not be a power of two).
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                          input logic [IW-1:0]      start);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  // Candidate selection: round robin when idle, owner only while locked.
  assign w_pick = rr_pick(req_valid, r_rr_ptr);

  always_comb begin
    w_sel_id  = w_pick[IW-1:0];
    w_sel_vld = w_pick[IW];
    if (r_state == LOCKED) begin
      w_sel_id  = r_owner;
      w_sel_vld = req_valid[r_owner];
    end
  end

  // FSM output process: the grant is withheld while full or in reset.
  always_comb begin
    req_ready = '0;
    if (!areset && !r_full && w_sel_vld) req_ready[w_sel_id] = 1'b1;
  end

  assign w_acc      = |(req_valid & req_ready);
  assign w_acc_last = req_last[w_sel_id];
  assign w_acc_data = req_data[int'(w_sel_id)*DWIDTH +: DWIDTH];

  // FSM next-state process.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc && !w_acc_last) w_state_nxt = LOCKED;
      LOCKED:  if (w_acc && w_acc_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Arbitration bookkeeping. While locked, the round-robin pointer only moves
  // when the owner closes its burst.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_grant_id <= '0;
    end else if (w_acc) begin
      r_grant_id <= w_sel_id;
      if (r_state == IDLE) begin
        r_rr_ptr <= wrap_inc(w_sel_id);
        if (!w_acc_last) r_owner <= w_sel_id;
      end else if (w_acc_last) begin
        r_rr_ptr <= wrap_inc(w_sel_id);
      end
    end
  end

  // Pointer arithmetic. The read pointer with its two MSBs inverted equals the
  // write pointer exactly when the write side is one full lap ahead.
  assign w_next_bin  = r_wr_bin + {{AWIDTH{1'b0}}, w_acc};
  assign w_next_gray = bin2gray(w_next_bin);
  assign w_rd_bin    = gray2bin(rd_ptr_gray_sync);
  assign w_full_cmp  = {~rd_ptr_gray_sync[AWIDTH:AWIDTH-1], rd_ptr_gray_sync[AWIDTH-2:0]};

  // Stage boundary: accept -> RAM write / pointer / status registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_bin      <= '0;
      r_wr_ptr_gray <= '0;
      r_full        <= 1'b0;
      r_fill        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
    end else begin
      r_wr_bin      <= w_next_bin;
      r_wr_ptr_gray <= w_next_gray;
      r_full        <= (w_next_gray == w_full_cmp);
      r_fill        <= w_next_bin - w_rd_bin;
      r_wr_en       <= w_acc;
      if (w_acc) begin
        r_wr_addr <= r_wr_bin[AWIDTH-1:0];
        r_wr_data <= w_acc_data;
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_ptr_gray = r_wr_ptr_gray;
  assign full        = r_full;
  assign fill_level  = r_fill;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PW = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << PW;

  logic             aclk = 1'b0;
  logic             areset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [PW-1:0]    rd_ptr_gray_sync;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [PW-1:0]    wr_ptr_gray;
  logic             full;
  logic [PW-1:0]    fill_level;
  logic [1:0]       grant_id;

  fifo_write_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .aclk(aclk), .areset(areset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .rd_ptr_gray_sync(rd_ptr_gray_sync),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ptr_gray(wr_ptr_gray),
    .full(full), .fill_level(fill_level), .grant_id(grant_id)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word counts modulo the pointer range plus arbitration state.
  int          m_wr, m_rd, m_owner, m_rr, m_gid, m_addr, m_fill, m_gray;
  bit          m_locked, m_wr_en, m_full;
  logic [31:0] m_data;
  bit          follow;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_rd(input int n);
    m_rd = n % PMOD;
    rd_ptr_gray_sync = PW'(m_rd ^ (m_rd >> 1));
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] l);
    req_valid = v;
    req_last  = l;
    req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (follow) set_rd(m_wr);
  endtask

  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] r;
    int i;
    r = '0;
    if (areset || m_full) return r;
    if (m_locked) begin
      if (req_valid[m_owner]) r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < NR; k++) begin
      i = (m_rr + k) % NR;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_update(input logic [NR-1:0] er);
    int id;
    int diff;
    bit acc;
    if (areset) begin
      m_wr = 0; m_locked = 0; m_owner = 0; m_rr = 0; m_gid = 0;
      m_wr_en = 0; m_addr = 0; m_data = 0; m_gray = 0; m_full = 0; m_fill = 0;
      return;
    end
    acc = |(er & req_valid);
    id = 0;
    for (int k = 0; k < NR; k++) if (er[k]) id = k;
    m_wr_en = acc;
    if (acc) begin
      m_addr = m_wr % DEPTH;
      m_data = req_data[id*DW +: DW];
      m_gid  = id;
      if (m_locked) begin
        if (req_last[id]) begin m_locked = 0; m_rr = (id + 1) % NR; end
      end else begin
        m_rr = (id + 1) % NR;
        if (!req_last[id]) begin m_locked = 1; m_owner = id; end
      end
      m_wr = (m_wr + 1) % PMOD;
    end
    m_gray = m_wr ^ (m_wr >> 1);
    diff   = (m_wr - m_rd + PMOD) % PMOD;
    m_full = (diff == DEPTH);
    m_fill = diff;
  endtask

  // One clock: compare the combinational grant, clock, compare registered outputs.
  task automatic tick();
    logic [NR-1:0] er;
    #1;
    er = model_ready();
    check("req_ready", req_ready, er);
    @(posedge aclk);
    model_update(er);
    #1;
    check("wr_en", wr_en, m_wr_en);
    check("wr_addr", wr_addr, m_addr);
    check("wr_data", wr_data, m_data);
    check("wr_ptr_gray", wr_ptr_gray, m_gray);
    check("full", full, m_full);
    check("fill_level", fill_level, m_fill);
    check("grant_id", grant_id, m_gid);
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    set_rd(0);
    drive(4'hF, 4'hF);
    tick();
    areset = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] prev_gray;
    logic [AW-1:0] prev_addr;
    int gray_wraps, addr_wraps, rsteps;
    int q_addr[$];

    m_wr = 0; m_rd = 0; m_owner = 0; m_rr = 0; m_gid = 0; m_addr = 0; m_fill = 0;
    m_gray = 0; m_locked = 0; m_wr_en = 0; m_full = 0; m_data = 0; follow = 0;
    areset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; set_rd(0);
    @(negedge aclk);

    // Reset state, with requesters asserting valid during reset.
    do_reset();
    areset = 1'b1;
    drive(4'hF, 4'hF);
    #1 check("ready_in_reset", req_ready, 0);
    tick();
    areset = 1'b0;

    // Requester 0 streams until full with the read pointer parked at 0.
    follow = 0;
    q_addr = {};
    for (int c = 0; c < 18; c++) begin
      drive(4'b0001, 4'b0001);
      tick();
      if (wr_en) q_addr.push_back(int'(wr_addr));
    end
    check("stream_count", q_addr.size(), 16);
    foreach (q_addr[k]) check("stream_addr", q_addr[k], k);
    check("full_after_16", full, 1);
    check("fill_after_16", fill_level, 16);
    #1 check("ready_when_full", req_ready, 0);

    // Read side advances to 5: full clears, fill becomes 11, writing resumes at 0.
    set_rd(5);
    tick();
    check("full_drop", full, 0);
    check("fill_11", fill_level, 11);
    tick();
    check("resume_en", wr_en, 1);
    check("resume_addr", wr_addr, 0);

    // Round robin with every requester valid and single-word bursts.
    do_reset();
    follow = 1;
    for (int c = 0; c < 12; c++) begin
      drive(4'hF, 4'hF);
      tick();
      check("rr_grant", grant_id, c % NR);
    end

    // Requester 2 locks for a 4-word burst with a bubble in the middle.
    do_reset();
    drive(4'b0001, 4'hF); tick();
    drive(4'b0010, 4'hF); tick();
    for (int c = 0; c < 3; c++) begin
      drive(4'hF, 4'b1011);
      tick();
      check("lock_grant", grant_id, 2);
    end
    drive(4'b1011, 4'b1011);
    #1 check("bubble_ready", req_ready, 0);
    tick();
    check("bubble_no_write", wr_en, 0);
    drive(4'hF, 4'hF); tick();
    check("lock_last", grant_id, 2);
    drive(4'hF, 4'hF); tick();
    check("after_lock", grant_id, 3);

    // Pointer wrap across 40 words with the read pointer following.
    do_reset();
    gray_wraps = 0; addr_wraps = 0; prev_addr = '0;
    for (int c = 0; c < 40; c++) begin
      prev_gray = wr_ptr_gray;
      drive(4'b0001, 4'b0001);
      tick();
      if (wr_ptr_gray != prev_gray)
        check("gray_one_bit", $countones(wr_ptr_gray ^ prev_gray), 1);
      if (prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000) gray_wraps++;
      if (wr_en && prev_addr == 4'd15 && wr_addr == 4'd0) addr_wraps++;
      if (wr_en) prev_addr = wr_addr;
    end
    check("gray_wrap", gray_wraps, 1);
    check("addr_wrap", addr_wraps, 2);

    // Reset in the middle of a locked burst from requester 1.
    do_reset();
    drive(4'b0010, 4'b0000); tick();
    drive(4'b0010, 4'b0000); tick();
    areset = 1'b1;
    drive(4'hF, 4'h0);
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_gray", wr_ptr_gray, 0);
    check("rst_full", full, 0);
    check("rst_fill", fill_level, 0);
    check("rst_gid", grant_id, 0);
    areset = 1'b0;
    drive(4'hF, 4'hF); tick();
    check("post_rst_grant", grant_id, 0);
    check("post_rst_write", wr_en, 1);

    // Random traffic, random read progress, occasional resets.
    follow = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(99) == 0) begin
        areset = 1'b1;
        set_rd(0);
      end else begin
        areset = 1'b0;
        if ($urandom_range(1) == 1) begin
          rsteps = (m_wr - m_rd + PMOD) % PMOD;
          set_rd(m_rd + $urandom_range(rsteps));
        end
      end
      drive(NR'($urandom()), NR'($urandom() | $urandom()));
      tick();
    end
    areset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
